// File: rtl/lcd_i2c_sender.sv
// rtl/lcd_i2c_sender.sv - HD44780 request to PCF8574-backpack I2C byte sequencer
//
// Turns one command/data request into an I2C transaction: the address byte,
// then 4-bit-mode nibble strobes (EN high, then EN low). Bytes go to the
// frame writer one at a time, and the block waits for wr_done after each one.
// busy stays high through a settle delay after the transaction.
//
// Optional build macro: LCD_SENDER_TIMEOUT_EN. It enables a per-byte watchdog.
// If wr_done does not arrive in time, the watchdog pulses err and drops back
// to idle.
//
// Ports:
//   clk_1MHz     in   1 MHz clock (1 us per cycle)
//   rst_n        in   asynchronous active-low reset
//   req          in   request strobe, accepted only while busy=0
//   rs           in   HD44780 RS (0 command, 1 data)
//   byte_in      in   command/data byte
//   nibble_mode  in   send only byte_in[7:4]
//   backlight    in   PCF8574 P3 level
//   busy         out  transaction or settle delay in progress
//   done         out  one-cycle pulse at end of settle
//   wr_en        out  frame writer en_write (one cycle per byte)
//   wr_start     out  frame writer start_frame (address byte only)
//   wr_stop      out  frame writer stop_frame (final byte only)
//   wr_data      out  frame writer data
//   wr_done      in   frame writer done
//   err          out  watchdog timeout pulse (0 without the macro)

module lcd_i2c_sender #(
    parameter logic [6:0] SLAVE_ADDR     = 7'h27,
    parameter int         SHORT_DELAY_US = 50,
    parameter int         LONG_DELAY_US  = 2000,
    parameter int         TIMEOUT_US     = 5000
) (
    input  logic       clk_1MHz,
    input  logic       rst_n,
    input  logic       req,
    input  logic       rs,
    input  logic [7:0] byte_in,
    input  logic       nibble_mode,
    input  logic       backlight,
    output logic       busy,
    output logic       done,
    output logic       wr_en,
    output logic       wr_start,
    output logic       wr_stop,
    output logic [7:0] wr_data,
    input  logic       wr_done,
    output logic       err
);

    if (SHORT_DELAY_US < 1 || SHORT_DELAY_US > 65535 ||
        LONG_DELAY_US < 1 || LONG_DELAY_US > 65535 ||
        TIMEOUT_US < 1 || TIMEOUT_US > 65535) begin : g_bad_param
        $error("lcd_i2c_sender: delay/timeout parameters must be 1..65535");
    end

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SETTLE, FIN} state_t;

    // The settle counter starts at 0 in the cycle after wr_done. Comparing
    // against delay-1 therefore puts done exactly delay cycles after wr_done.
    localparam logic [15:0] SHORT_LAST = 16'(SHORT_DELAY_US - 1);
    localparam logic [15:0] LONG_LAST  = 16'(LONG_DELAY_US - 1);

    state_t      state;
    logic        rs_q;
    logic [7:0]  byte_q;
    logic        nm_q;
    logic        bl_q;
    logic [2:0]  idx;          // 0 = address byte, 1..last_idx = nibble strobes
    logic [15:0] settle_cnt;

    logic [2:0]  last_idx;
    logic [2:0]  nxt_idx;
    logic        long_settle;

    assign last_idx    = nm_q ? 3'd2 : 3'd4;
    assign nxt_idx     = idx + 3'd1;
    assign long_settle = !rs_q && !nm_q && (byte_q == 8'h01 || byte_q == 8'h02);

    // PCF8574 pin map: P7..P4 = D7..D4, P3 = BL, P2 = EN, P1 = RW (0), P0 = RS
    function automatic logic [7:0] frame_byte(input logic [2:0] sel, input logic [7:0] b,
                                              input logic bl, input logic r);
        case (sel)
            3'd0:    frame_byte = {SLAVE_ADDR, 1'b0};
            3'd1:    frame_byte = {b[7:4], bl, 1'b1, 1'b0, r};
            3'd2:    frame_byte = {b[7:4], bl, 1'b0, 1'b0, r};
            3'd3:    frame_byte = {b[3:0], bl, 1'b1, 1'b0, r};
            default: frame_byte = {b[3:0], bl, 1'b0, 1'b0, r};
        endcase
    endfunction

`ifdef LCD_SENDER_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_US - 1);
    logic [15:0] wd_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rs_q       <= 1'b0;
            byte_q     <= 8'h00;
            nm_q       <= 1'b0;
            bl_q       <= 1'b0;
            idx        <= 3'd0;
            settle_cnt <= 16'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_en      <= 1'b0;
            wr_start   <= 1'b0;
            wr_stop    <= 1'b0;
            wr_data    <= 8'h00;
`ifdef LCD_SENDER_TIMEOUT_EN
            wd_cnt     <= 16'd0;
            err        <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef LCD_SENDER_TIMEOUT_EN
            err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req) begin
                        rs_q     <= rs;
                        byte_q   <= byte_in;
                        nm_q     <= nibble_mode;
                        bl_q     <= backlight;
                        idx      <= 3'd0;
                        busy     <= 1'b1;
                        wr_en    <= 1'b1;
                        wr_start <= 1'b1;
                        wr_stop  <= 1'b0;
                        wr_data  <= {SLAVE_ADDR, 1'b0};
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // wr_en is a single-cycle strobe; data/start/stop are held
                    wr_en <= 1'b0;
`ifdef LCD_SENDER_TIMEOUT_EN
                    wd_cnt <= 16'd0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (wr_done) begin
                        if (idx != last_idx) begin
                            idx      <= nxt_idx;
                            wr_en    <= 1'b1;
                            wr_start <= 1'b0;
                            wr_stop  <= (nxt_idx == last_idx);
                            wr_data  <= frame_byte(nxt_idx, byte_q, bl_q, rs_q);
                            state    <= ISSUE;
                        end else begin
                            wr_stop    <= 1'b0;
                            settle_cnt <= 16'd0;
                            state      <= SETTLE;
                        end
                    end
`ifdef LCD_SENDER_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        wr_en    <= 1'b0;
                        wr_start <= 1'b0;
                        wr_stop  <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`endif
                end
                SETTLE: begin
                    if (settle_cnt == (long_settle ? LONG_LAST : SHORT_LAST)) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        settle_cnt <= settle_cnt + 16'd1;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_i2c_sender.sv
// tb/tb_lcd_i2c_sender.sv - self-checking bench for lcd_i2c_sender

module tb_lcd_i2c_sender;

    localparam int SHORT = 50;
    localparam int LONG  = 2000;
    localparam int TMO   = 5000;
    localparam int ADDR  = 'h27;

    logic       clk_1MHz = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       rs = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       nibble_mode = 1'b0;
    logic       backlight = 1'b0;
    logic       wr_done = 1'b0;
    logic       busy, done, wr_en, wr_start, wr_stop, err;
    logic [7:0] wr_data;

    lcd_i2c_sender dut (
        .clk_1MHz   (clk_1MHz),
        .rst_n      (rst_n),
        .req        (req),
        .rs         (rs),
        .byte_in    (byte_in),
        .nibble_mode(nibble_mode),
        .backlight  (backlight),
        .busy       (busy),
        .done       (done),
        .wr_en      (wr_en),
        .wr_start   (wr_start),
        .wr_stop    (wr_stop),
        .wr_data    (wr_data),
        .wr_done    (wr_done),
        .err        (err)
    );

    always #5 clk_1MHz = ~clk_1MHz;

    int cyc = 0;
    always @(posedge clk_1MHz) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Reference model: the byte list and settle time that the request should produce
    int exp_q[$];
    int exp_delay;

    task automatic model(input int r, input int b, input int nm, input int bl);
        int hi, lo;
        hi = b / 16;
        lo = b % 16;
        exp_q = {};
        exp_q.push_back(ADDR * 2);
        exp_q.push_back(hi * 16 + bl * 8 + 4 + r);
        exp_q.push_back(hi * 16 + bl * 8 + r);
        if (nm == 0) begin
            exp_q.push_back(lo * 16 + bl * 8 + 4 + r);
            exp_q.push_back(lo * 16 + bl * 8 + r);
        end
        exp_delay = (r == 0 && nm == 0 && (b == 1 || b == 2)) ? LONG : SHORT;
    endtask

    // Runs one request. abort_at >= 0 resets the DUT while that byte is issued.
    task automatic run_txn(input int r, input int b, input int nm, input int bl,
                           input int lat_min, input int lat_max, input int poke, input int abort_at);
        int lat, t0, n, last;
        logic stable, busy_ok;
        model(r, b, nm, bl);
        last = exp_q.size() - 1;
        @(negedge clk_1MHz);
        rs = 1'(r); byte_in = 8'(b); nibble_mode = 1'(nm); backlight = 1'(bl); req = 1'b1;
        @(negedge clk_1MHz);
        req = 1'b0;
        rs = 1'($urandom); byte_in = 8'($urandom); nibble_mode = 1'($urandom); backlight = 1'($urandom);
        check("busy_on_accept", busy, 1);
        t0 = 0;
        for (int k = 0; k <= last; k++) begin
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_outputs", {busy, done, wr_en, wr_start, wr_stop, err, wr_data}, 0);
                @(negedge clk_1MHz);
                check("abort_held", {busy, wr_en, wr_data}, 0);
                rst_n = 1'b1;
                return;
            end
            check($sformatf("wr_en_b%0d", k), wr_en, 1);
            check($sformatf("wr_data_b%0d", k), wr_data, exp_q[k]);
            check($sformatf("wr_start_b%0d", k), wr_start, (k == 0));
            check($sformatf("wr_stop_b%0d", k), wr_stop, (k == last));
            lat = $urandom_range(lat_max, lat_min);
            stable = 1'b1;
            for (int i = 0; i < lat; i++) begin
                @(negedge clk_1MHz);
                req = (poke != 0 && i == 3) ? 1'b1 : 1'b0;
                if (wr_en !== 1'b0 || wr_data !== 8'(exp_q[k]) || wr_start !== (k == 0) ||
                    wr_stop !== (k == last) || busy !== 1'b1)
                    stable = 1'b0;
            end
            req = 1'b0;
            check($sformatf("hold_b%0d", k), stable, 1);
            wr_done = 1'b1;
            @(negedge clk_1MHz);
            wr_done = 1'b0;
            t0 = cyc;
        end
        n = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < exp_delay + 10) begin
            if (busy !== 1'b1 || wr_en !== 1'b0) busy_ok = 1'b0;
            @(negedge clk_1MHz);
            wr_done = (n == 4) ? 1'b1 : 1'b0;  // stray wr_done during settle
            n++;
        end
        wr_done = 1'b0;
        check("settle_busy", busy_ok, 1);
        check("settle_cycles", cyc - t0, exp_delay);
        check("busy_at_done", busy, 1);
        @(negedge clk_1MHz);
        check("done_pulse_end", done, 0);
        check("busy_after_done", busy, 0);
        @(negedge clk_1MHz);
        check("no_queued_req", {busy, wr_en}, 0);
    endtask

    initial begin
        int t_wait;
        int n;
        logic saw_done;

        repeat (3) @(negedge clk_1MHz);
        check("reset_outputs", {busy, done, wr_en, wr_start, wr_stop, err, wr_data}, 0);
        rst_n = 1'b1;
        @(negedge clk_1MHz);
        check("idle_after_reset", {busy, wr_en}, 0);

        run_txn(1, 'h41, 0, 1, 1, 4, 0, -1);
        run_txn(0, 'h01, 0, 1, 1, 4, 0, -1);
        run_txn(0, 'h30, 1, 0, 1, 4, 0, -1);
        run_txn(0, 'h01, 1, 1, 1, 4, 0, -1);
        run_txn(0, 'h02, 0, 0, 1, 4, 0, -1);

        for (int t = 0; t < 3; t++)
            run_txn($urandom_range(1, 0), $urandom_range(255, 3), $urandom_range(1, 0),
                    $urandom_range(1, 0), 100, 400, 1, -1);

        run_txn(1, 'h41, 0, 1, 1, 3, 0, 2);
        run_txn(1, 'h41, 0, 1, 1, 3, 0, -1);

        for (int t = 0; t < 6; t++)
            run_txn($urandom_range(1, 0), $urandom_range(255, 3), $urandom_range(1, 0),
                    $urandom_range(1, 0), 1, 8, 0, -1);

        // Withheld wr_done on the address byte
        @(negedge clk_1MHz);
        rs = 1'b1; byte_in = 8'h41; nibble_mode = 1'b0; backlight = 1'b1; req = 1'b1;
        @(negedge clk_1MHz);
        req = 1'b0;
        check("tmo_addr_issue", {wr_en, wr_data}, {1'b1, 8'h4E});
        t_wait = cyc + 1;
        n = 0;
        saw_done = 1'b0;
`ifdef LCD_SENDER_TIMEOUT_EN
        while (err !== 1'b1 && n < TMO + 20) begin
            @(negedge clk_1MHz);
            if (done === 1'b1) saw_done = 1'b1;
            n++;
        end
        check("tmo_err_time", cyc - t_wait, TMO);
        check("tmo_err", err, 1);
        check("tmo_outputs", {busy, done, wr_en, wr_start, wr_stop}, 0);
        check("tmo_no_done", saw_done, 0);
        @(negedge clk_1MHz);
        check("tmo_err_pulse", {err, busy}, 0);
`else
        while (n < TMO + 20) begin
            @(negedge clk_1MHz);
            if (done === 1'b1 || err !== 1'b0) saw_done = 1'b1;
            n++;
        end
        check("no_tmo_busy", busy, 1);
        check("no_tmo_err_done", saw_done, 0);
        rst_n = 1'b0;
        @(negedge clk_1MHz);
        rst_n = 1'b1;
`endif
        run_txn(0, 'h30, 1, 1, 1, 4, 0, -1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
